// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
package seq_det_pkg;

    localparam int MAX_LEN_DEF = 8;
    localparam int LEN_W_DEF   = 4;
    localparam int CNT_W_DEF   = 8;
    localparam int MASK_W      = 32;

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    // Low-order mask of len ones; callers truncate to their pattern width.
    function automatic logic [MASK_W-1:0] len_mask(input int unsigned len);
        if (len >= MASK_W) return '1;
        return (MASK_W'(1) << len) - MASK_W'(1);
    endfunction

endpackage

// File: rtl/seq_match_cmp.sv
// Masked history-vs-pattern compare with fill qualification; purely combinational.
module seq_match_cmp
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int LEN_W   = LEN_W_DEF
) (
    input  logic [MAX_LEN-1:0] hist_n,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    input  logic [LEN_W-1:0]   fill_n,
    output logic               hit
);

    logic [MAX_LEN-1:0] mask;

    assign mask = MAX_LEN'(len_mask(32'(len)));
    assign hit  = (fill_n >= len) && (((hist_n ^ pattern) & mask) == '0);

endmodule

// File: rtl/seq_det_prog.sv
// Run-time programmable serial bit-pattern detector with registered match
// pulse and saturating match counter.
module seq_det_prog
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int LEN_W   = LEN_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               x_valid,
    input  logic               x,
    input  logic               cnt_clr,
    output logic               z,
    output logic [CNT_W-1:0]   match_count,
    output logic               cfg_err,
    output logic               armed
);

    state_t             state;
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   len;
    logic               overlap;
    logic [MAX_LEN-1:0] hist;
    logic [LEN_W-1:0]   fill;

    logic [MAX_LEN-1:0] hist_n;
    logic [LEN_W-1:0]   fill_n;
    logic               hit;
    logic               consume;
    logic               hit_run;
    logic               len_ok;

    assign hist_n  = {hist[MAX_LEN-2:0], x};
    assign fill_n  = (fill == LEN_W'(MAX_LEN)) ? fill : fill + LEN_W'(1);
    assign consume = (state == ST_RUN) && x_valid && !cfg_load;
    assign hit_run = consume && hit;
    assign len_ok  = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));

    seq_match_cmp #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_cmp (
        .hist_n  (hist_n),
        .pattern (pattern),
        .len     (len),
        .fill_n  (fill_n),
        .hit     (hit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            pattern     <= '0;
            len         <= '0;
            overlap     <= 1'b0;
            hist        <= '0;
            fill        <= '0;
            z           <= 1'b0;
            match_count <= '0;
            cfg_err     <= 1'b0;
            armed       <= 1'b0;
        end else begin
            z       <= 1'b0;
            cfg_err <= 1'b0;

            // Clear wins over a coincident hit; z still reports that hit.
            if (cnt_clr)
                match_count <= '0;
            else if (hit_run && match_count != '1)
                match_count <= match_count + CNT_W'(1);

            if (cfg_load) begin
                if (len_ok) begin
                    pattern <= cfg_pattern;
                    len     <= cfg_len;
                    overlap <= cfg_overlap;
                    hist    <= '0;
                    fill    <= '0;
                    state   <= ST_RUN;
                    armed   <= 1'b1;
                end else begin
                    cfg_err <= 1'b1;
                    state   <= ST_IDLE;
                    armed   <= 1'b0;
                end
            end else if (consume) begin
                hist <= hist_n;
                fill <= (hit && !overlap) ? '0 : fill_n;
                z    <= hit;
            end
        end
    end

endmodule

// File: tb/tb_seq_det_prog.sv
// Directed bench for seq_det_prog: default instance plus a CNT_W=2 instance
// sharing the same stimulus to exercise counter saturation.
module tb_seq_det_prog;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               cfg_load = 1'b0;
    logic [MAX_LEN-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0]   cfg_len = '0;
    logic               cfg_overlap = 1'b0;
    logic               x_valid = 1'b0;
    logic               x = 1'b0;
    logic               cnt_clr = 1'b0;

    logic       z, cfg_err, armed;
    logic [7:0] match_count;
    logic       s_z, s_cfg_err, s_armed;
    logic [1:0] s_match_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_det_prog #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(8)) u_dut (
        .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .x_valid(x_valid), .x(x),
        .cnt_clr(cnt_clr), .z(z), .match_count(match_count), .cfg_err(cfg_err),
        .armed(armed)
    );

    seq_det_prog #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .x_valid(x_valid), .x(x),
        .cnt_clr(cnt_clr), .z(s_z), .match_count(s_match_count), .cfg_err(s_cfg_err),
        .armed(s_armed)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive, let the edge happen, sample 1 time unit later.
    task automatic step(input logic v, input logic b);
        x_valid = v;
        x       = b;
        @(posedge clk);
        #1;
        x_valid  = 1'b0;
        x        = 1'b0;
        cnt_clr  = 1'b0;
        cfg_load = 1'b0;
    endtask

    task automatic load(input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len,
                        input logic ov);
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ov;
        cfg_load    = 1'b1;
        step(1'b0, 1'b0);
    endtask

    task automatic clr();
        cnt_clr = 1'b1;
        step(1'b0, 1'b0);
    endtask

    // Bit n-1 of each vector is applied first.
    task automatic run(input string tag, input logic [15:0] xs, input logic [15:0] vs,
                       input logic [15:0] zs, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            step(vs[i], xs[i]);
            chk($sformatf("%s_z%0d", tag, n - i), z, zs[i]);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_z", z, 0);
        chk("rst_cnt", match_count, 0);
        chk("rst_err", cfg_err, 0);
        chk("rst_armed", armed, 0);
        reset = 1'b1;

        // Unconfigured: x_valid ignored.
        run("idle", 16'h03ff, 16'h03ff, 16'h0000, 10);
        chk("idle_armed", armed, 0);
        chk("idle_cnt", match_count, 0);

        // 0110 overlapping.
        load(8'b0110, 4'd4, 1'b1);
        chk("ov_armed", armed, 1);
        run("ov", 16'b0110110, 16'h7f, 16'b0001001, 7);
        chk("ov_cnt", match_count, 2);

        // 0110 non-overlapping.
        clr();
        load(8'b0110, 4'd4, 1'b0);
        run("nov", 16'b0110110110, 16'h3ff, 16'b0001000001, 10);
        chk("nov_cnt", match_count, 2);

        // Illegal lengths.
        load(8'b0110, 4'd0, 1'b0);
        chk("len0_err", cfg_err, 1);
        chk("len0_armed", armed, 0);
        step(1'b0, 1'b0);
        chk("len0_err_pulse", cfg_err, 0);
        load(8'b0110, 4'(MAX_LEN + 1), 1'b0);
        chk("len9_err", cfg_err, 1);
        chk("len9_armed", armed, 0);

        // 101 with gaps in x_valid.
        clr();
        load(8'b101, 4'd3, 1'b1);
        chk("gap_err", cfg_err, 0);
        run("gap", 16'b100001, 16'b101001, 16'b000001, 6);
        chk("gap_cnt", match_count, 1);

        // len=1 saturation on the CNT_W=2 instance.
        clr();
        load(8'b1, 4'd1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1);
            chk($sformatf("sat_z%0d", i), s_z, 1);
            chk($sformatf("sat_cnt%0d", i), s_match_count, (i < 3) ? i + 1 : 3);
        end
        chk("sat_wide_cnt", match_count, 5);
        step(1'b1, 1'b0);
        chk("len1_zero_bit", z, 0);
        cnt_clr = 1'b1;
        step(1'b1, 1'b1);
        chk("clr_hit_z", z, 1);
        chk("clr_hit_cnt", match_count, 0);
        chk("clr_hit_sat_cnt", s_match_count, 0);

        // Reset mid-pattern.
        load(8'b0110, 4'd4, 1'b1);
        run("pre_rst", 16'b011, 16'b111, 16'b000, 3);
        reset = 1'b0;
        #2;
        chk("mid_rst_z", z, 0);
        chk("mid_rst_armed", armed, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        load(8'b0110, 4'd4, 1'b1);
        run("post_rst", 16'b0110, 16'hf, 16'b0001, 4);
        chk("post_rst_cnt", match_count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
